// File: rtl/axil_pkg.sv
// Shared definitions for the AXI4-Lite initiator: FSM states, response codes, default widths.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package axil_pkg;

  localparam int AXIL_ADDR_W  = 32;
  localparam int AXIL_DATA_W  = 32;
  localparam int AXIL_STRB_W  = 8;
  localparam int AXIL_TIMEOUT = 1024;

  typedef enum logic [2:0] {
    IDLE,
    RD_ADDR,
    RD_DATA,
    WR_REQ,
    WR_RESP,
    RESP
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/axil_watchdog.sv
// Transaction watchdog: cycle counter with a sticky expiry flag.
// Latency: expire_o is combinational from the counter; timeout_o is set on the expiring edge.
// Backpressure: none; the counter only runs while busy_i is high.
//
// Ports:
//   clk, rst   - clock, synchronous active-high reset
//   clear_i    - restart the count (a new transaction is starting)
//   busy_i     - a bus transaction is outstanding this cycle
//   expire_o   - limit reached this cycle while busy
//   timeout_o  - sticky flag, cleared only by rst
module axil_watchdog #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic busy_i,
  output logic expire_o,
  output logic timeout_o
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             to_q, to_d;

  assign expire_o  = busy_i && (cnt_q == LIMIT);
  assign timeout_o = to_q;

  always_comb begin
    cnt_d = cnt_q;
    to_d  = to_q | expire_o;
    if (clear_i) begin
      cnt_d = '0;
    end else if (busy_i && !expire_o) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      to_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      to_q  <= to_d;
    end
  end

endmodule

// File: rtl/axil_master_bridge.sv
// AXI4-Lite initiator: turns one core request at a time into an AR/R read or AW/W/B write.
// Latency: 3 cycles from request accept to resp_valid with zero-wait slaves.
// Backpressure: req_ready only in IDLE; resp_valid held with stable data until resp_ready.
//
// Optional feature macro: AXIM_TIMEOUT_EN (watchdog aborts a stuck transaction with an error).
//
// Ports:
//   clk, rst                         - clock, synchronous active-high reset
//   req_*                            - core request (valid/ready, write flag, address, data, mask)
//   resp_*                           - core response (valid/ready, read data, error)
//   ar*/r*, aw*/w*/b*                - AXI4-Lite initiator channels
//   timeout                          - sticky watchdog flag (0 when the feature is off)
module axil_master_bridge
  import axil_pkg::*;
#(
  parameter int ADDR_W         = AXIL_ADDR_W,
  parameter int DATA_W         = AXIL_DATA_W,
  parameter int STRB_W         = AXIL_STRB_W,
  parameter int TIMEOUT_CYCLES = AXIL_TIMEOUT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_wen,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_wmask,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [DATA_W-1:0]   resp_rdata,
  output logic                resp_err,
  output logic [ADDR_W-1:0]   araddr,
  output logic                arvalid,
  input  logic                arready,
  input  logic [DATA_W-1:0]   rdata,
  input  logic [1:0]          rresp,
  input  logic                rvalid,
  output logic                rready,
  output logic [ADDR_W-1:0]   awaddr,
  output logic                awvalid,
  input  logic                awready,
  output logic [DATA_W-1:0]   wdata,
  output logic [STRB_W-1:0]   wstrb,
  output logic                wvalid,
  input  logic                wready,
  input  logic [1:0]          bresp,
  input  logic                bvalid,
  output logic                bready,
  output logic                timeout
);

  localparam int MASK_W = DATA_W / 8;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [STRB_W-1:0]   wstrb_q, wstrb_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                err_q, err_d;
  logic                aw_done_q, aw_done_d;
  logic                w_done_q, w_done_d;

  logic accept;
  logic busy;
  logic wd_expire;

  // Byte-offset bits and the watchdog limit are legitimately unused in some builds.
  logic unused_ok;
  assign unused_ok = &{1'b0, req_addr[1:0], TIMEOUT_CYCLES[0]};

  assign accept = (state_q == IDLE) && req_valid;
  assign busy   = (state_q == RD_ADDR) || (state_q == RD_DATA) ||
                  (state_q == WR_REQ)  || (state_q == WR_RESP);

`ifdef AXIM_TIMEOUT_EN
  axil_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk       (clk),
    .rst       (rst),
    .clear_i   (accept),
    .busy_i    (busy),
    .expire_o  (wd_expire),
    .timeout_o (timeout)
  );
`else
  assign wd_expire = 1'b0;
  assign timeout   = 1'b0;
  logic unused_busy;
  assign unused_busy = busy;
`endif

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;

    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_d    = {req_addr[ADDR_W-1:2], 2'b00};
          wdata_d   = req_wdata;
          wstrb_d   = {{(STRB_W-MASK_W){1'b0}}, req_wmask};
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = req_wen ? WR_REQ : RD_ADDR;
        end
      end
      RD_ADDR: begin
        if (arready) state_d = RD_DATA;
      end
      RD_DATA: begin
        if (rvalid) begin
          rdata_d = rdata;
          err_d   = (rresp != RESP_OKAY);
          state_d = RESP;
        end
      end
      WR_REQ: begin
        // AW and W complete independently; leave once both have handshaken.
        aw_done_d = aw_done_q | awready;
        w_done_d  = w_done_q  | wready;
        if (aw_done_d && w_done_d) state_d = WR_RESP;
      end
      WR_RESP: begin
        if (bvalid) begin
          rdata_d = '0;
          err_d   = (bresp != RESP_OKAY);
          state_d = RESP;
        end
      end
      RESP: begin
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // An expired watchdog overrides any handshake landing in the same cycle.
    if (wd_expire) begin
      rdata_d = '0;
      err_d   = 1'b1;
      state_d = RESP;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

  // Every output is a decode of registered state, so it only moves on clk edges.
  assign req_ready  = (state_q == IDLE);
  assign arvalid    = (state_q == RD_ADDR);
  assign araddr     = addr_q;
  assign rready     = (state_q == RD_DATA);
  assign awvalid    = (state_q == WR_REQ) && !aw_done_q;
  assign awaddr     = addr_q;
  assign wvalid     = (state_q == WR_REQ) && !w_done_q;
  assign wdata      = wdata_q;
  assign wstrb      = wstrb_q;
  assign bready     = (state_q == WR_RESP);
  assign resp_valid = (state_q == RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

  // A slave response outside its own state is a protocol violation; it is ignored above.
  a_rvalid_in_rd_data: assert property (@(posedge clk) disable iff (rst)
    rvalid |-> (state_q == RD_DATA));
  a_bvalid_in_wr_resp: assert property (@(posedge clk) disable iff (rst)
    bvalid |-> (state_q == WR_RESP));

endmodule

// File: tb/tb_axil_master_bridge.sv
module tb_axil_master_bridge;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int STRB_W = 8;
  localparam int TO_CYC = 16;

  logic                clk;
  logic                rst;
  logic                req_valid;
  logic                req_ready;
  logic                req_wen;
  logic [ADDR_W-1:0]   req_addr;
  logic [DATA_W-1:0]   req_wdata;
  logic [DATA_W/8-1:0] req_wmask;
  logic                resp_valid;
  logic                resp_ready;
  logic [DATA_W-1:0]   resp_rdata;
  logic                resp_err;
  logic [ADDR_W-1:0]   araddr;
  logic                arvalid;
  logic                arready;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rvalid;
  logic                rready;
  logic [ADDR_W-1:0]   awaddr;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [STRB_W-1:0]   wstrb;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;
  logic                timeout;

  int total = 0;
  int bad   = 0;

  axil_master_bridge #(
    .ADDR_W         (ADDR_W),
    .DATA_W         (DATA_W),
    .STRB_W         (STRB_W),
    .TIMEOUT_CYCLES (TO_CYC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_wen    (req_wen),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_wmask  (req_wmask),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .araddr     (araddr),
    .arvalid    (arvalid),
    .arready    (arready),
    .rdata      (rdata),
    .rresp      (rresp),
    .rvalid     (rvalid),
    .rready     (rready),
    .awaddr     (awaddr),
    .awvalid    (awvalid),
    .awready    (awready),
    .wdata      (wdata),
    .wstrb      (wstrb),
    .wvalid     (wvalid),
    .wready     (wready),
    .bresp      (bresp),
    .bvalid     (bvalid),
    .bready     (bready),
    .timeout    (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Absolute time limit; the directed sequence never waits on the DUT, so this only trips on a hang.
  initial begin
    #200000;
    $display("FAIL sim_time_limit: bench did not finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string pfx);
    chk({pfx, "_req_ready"},  64'(req_ready),  64'd1);
    chk({pfx, "_valids"},     64'({arvalid, rready, awvalid, wvalid, bready, resp_valid}), 64'd0);
    chk({pfx, "_resp_rdata"}, 64'(resp_rdata), 64'd0);
    chk({pfx, "_resp_err"},   64'(resp_err),   64'd0);
    chk({pfx, "_timeout"},    64'(timeout),    64'd0);
    chk({pfx, "_addr_data"},  64'({araddr, awaddr} | 64'(wdata) | 64'(wstrb)), 64'd0);
  endtask

  // Zero-wait read (arready must already be high); leaves the DUT in RESP.
  task automatic read_to_resp(input logic [31:0] a, input logic [31:0] d, input logic [1:0] rr);
    req_valid = 1'b1;
    req_wen   = 1'b0;
    req_addr  = a;
    tick();               // accept
    req_valid = 1'b0;
    tick();               // AR handshake
    rvalid = 1'b1;
    rdata  = d;
    rresp  = rr;
    tick();               // R handshake
    rvalid = 1'b0;
    rresp  = 2'b00;
  endtask

  initial begin
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_wen    = 1'b0;
    req_addr   = '0;
    req_wdata  = '0;
    req_wmask  = '0;
    resp_ready = 1'b0;
    arready    = 1'b0;
    rdata      = '0;
    rresp      = 2'b00;
    rvalid     = 1'b0;
    awready    = 1'b0;
    wready     = 1'b0;
    bresp      = 2'b00;
    bvalid     = 1'b0;

    tick();
    tick();
    chk_reset_outputs("rst");
    rst = 1'b0;
    tick();

    // ---- Read with zero-wait slave ----
    arready   = 1'b1;
    req_valid = 1'b1;
    req_wen   = 1'b0;
    req_addr  = 32'h8000_0004;
    tick();                               // accept edge
    req_valid = 1'b0;
    chk("rd_arvalid",    64'(arvalid),   64'd1);
    chk("rd_araddr",     64'(araddr),    64'h8000_0004);
    chk("rd_req_ready0", 64'(req_ready), 64'd0);
    tick();                               // AR handshake
    chk("rd_rready",     64'(rready),    64'd1);
    chk("rd_arvalid0",   64'(arvalid),   64'd0);
    chk("rd_early_resp", 64'(resp_valid), 64'd0);
    rvalid = 1'b1;
    rdata  = 32'hDEAD_BEEF;
    tick();                               // R handshake; third cycle after accept is RESP
    rvalid = 1'b0;
    chk("rd_resp_valid", 64'(resp_valid), 64'd1);
    chk("rd_resp_rdata", 64'(resp_rdata), 64'hDEAD_BEEF);
    chk("rd_resp_err",   64'(resp_err),   64'd0);
    resp_ready = 1'b1;
    tick();
    chk("rd_back_idle",  64'({req_ready, resp_valid}), 64'b10);

    // ---- Write, AW ready two cycles before W ----
    arready   = 1'b0;
    req_valid = 1'b1;
    req_wen   = 1'b1;
    req_addr  = 32'h8000_0010;
    req_wdata = 32'h1234_5678;
    req_wmask = 4'b0011;
    tick();                               // accept
    req_valid = 1'b0;
    chk("wr_aw_w_valid", 64'({awvalid, wvalid}), 64'b11);
    chk("wr_awaddr",     64'(awaddr), 64'h8000_0010);
    chk("wr_wdata",      64'(wdata),  64'h1234_5678);
    chk("wr_wstrb",      64'(wstrb),  64'h03);
    awready = 1'b1;
    tick();                               // AW handshake
    awready = 1'b0;
    chk("wr_aw_dropped", 64'({awvalid, wvalid}), 64'b01);
    tick();
    chk("wr_w_held",     64'({awvalid, wvalid, bready}), 64'b010);
    wready = 1'b1;
    tick();                               // W handshake
    wready = 1'b0;
    chk("wr_bready",     64'({awvalid, wvalid, bready}), 64'b001);
    bvalid = 1'b1;
    bresp  = 2'b00;
    tick();                               // B handshake
    bvalid = 1'b0;
    chk("wr_one_b",      64'(bready),     64'd0);
    chk("wr_resp_valid", 64'(resp_valid), 64'd1);
    chk("wr_resp_err",   64'(resp_err),   64'd0);
    chk("wr_rdata_zero", 64'(resp_rdata), 64'd0);
    tick();                               // resp_ready still high
    chk("wr_back_idle",  64'(req_ready),  64'd1);

    // ---- Error response, then OKAY clears it ----
    arready = 1'b1;
    read_to_resp(32'h8000_0020, 32'hCAFE_F00D, 2'b10);
    chk("err_resp_err",   64'(resp_err),   64'd1);
    chk("err_resp_rdata", 64'(resp_rdata), 64'hCAFE_F00D);
    tick();
    read_to_resp(32'h8000_0024, 32'h1111_2222, 2'b00);
    chk("ok_resp_err",    64'(resp_err),   64'd0);
    chk("ok_resp_rdata",  64'(resp_rdata), 64'h1111_2222);
    tick();

    // ---- Back-pressure on the response, then misaligned read ----
    resp_ready = 1'b0;
    read_to_resp(32'h8000_0030, 32'h0BAD_F00D, 2'b00);
    req_valid = 1'b1;                     // next request waits behind the response
    req_wen   = 1'b0;
    req_addr  = 32'h8000_0007;
    for (int i = 0; i < 5; i++) begin
      chk("bp_resp_valid", 64'(resp_valid), 64'd1);
      chk("bp_resp_rdata", 64'(resp_rdata), 64'h0BAD_F00D);
      chk("bp_req_ready",  64'(req_ready),  64'd0);
      tick();
    end
    resp_ready = 1'b1;
    tick();                               // resp handshake; no accept on this edge
    chk("bp_after_hs",   64'({req_ready, resp_valid, arvalid}), 64'b100);
    resp_ready = 1'b0;
    tick();                               // accept the waiting request
    req_valid = 1'b0;
    chk("mis_arvalid",   64'(arvalid), 64'd1);
    chk("mis_araddr",    64'(araddr),  64'h8000_0004);
    tick();
    rvalid = 1'b1;
    rdata  = 32'h55AA_55AA;
    tick();
    rvalid = 1'b0;
    chk("mis_rdata",     64'(resp_rdata), 64'h55AA_55AA);
    resp_ready = 1'b1;
    tick();

    // ---- Stuck slave: arready never rises ----
    arready   = 1'b0;
    req_valid = 1'b1;
    req_wen   = 1'b0;
    req_addr  = 32'h8000_0040;
    tick();                               // accept
    req_valid = 1'b0;
    resp_ready = 1'b0;
    for (int i = 1; i < TO_CYC; i++) tick();
    chk("stuck_still_waiting", 64'({arvalid, resp_valid}), 64'b10);
    tick();                               // watchdog limit edge when enabled
`ifdef AXIM_TIMEOUT_EN
    chk("to_resp_valid", 64'(resp_valid), 64'd1);
    chk("to_resp_err",   64'(resp_err),   64'd1);
    chk("to_rdata_zero", 64'(resp_rdata), 64'd0);
    chk("to_flag",       64'(timeout),    64'd1);
    chk("to_arvalid0",   64'(arvalid),    64'd0);
    resp_ready = 1'b1;
    tick();
    chk("to_sticky",     64'({timeout, req_ready}), 64'b11);
    resp_ready = 1'b0;
    req_valid  = 1'b1;
    req_addr   = 32'h8000_0050;
    tick();                               // start another read that will be reset mid-flight
    req_valid = 1'b0;
    tick();
    chk("to_sticky2",    64'({timeout, arvalid}), 64'b11);
`else
    for (int i = 0; i < 20; i++) tick();
    chk("nto_waits",     64'({arvalid, resp_valid, timeout}), 64'b100);
`endif

    // ---- Reset mid-read ----
    rst = 1'b1;
    tick();
    chk_reset_outputs("midrst");
    rst = 1'b0;
    tick();
    chk("post_rst_idle", 64'({req_ready, arvalid}), 64'b10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axil_master_bridge.md
Name: axil_master_bridge

Overview:
- AXI4-Lite initiator that connects the core's simple request/response port (IFU fetch or LSU load/store) to the AXI4-Lite slaves (instruction memory, data memory).
- Accepts one request at a time from the core and runs the matching AXI read (AR/R) or write (AW/W/B) transaction.
- Returns read data and an error flag to the core.
- Sits between the multicycle core and the memory slaves; it is the initiator end of the same 5-channel bus.

Parameters:
- ADDR_W, 32, address width for both the core port and the bus.
- DATA_W, 32, data width.
- STRB_W, 8, bus wstrb width; the core supplies DATA_W/8 bits, and the upper bits are driven 0.
- TIMEOUT_CYCLES, 1024, watchdog limit (used only with the optional feature).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid  in  1  core request valid
- req_ready  out  1  bridge can accept a request
- req_wen  in  1  1 = write, 0 = read
- req_addr  in  ADDR_W  byte address
- req_wdata  in  DATA_W  write data, already lane-aligned by the core
- req_wmask  in  DATA_W/8  byte enables
- resp_valid  out  1  response valid
- resp_ready  in  1  core accepts the response
- resp_rdata  out  DATA_W  read data (0 for writes)
- resp_err  out  1  rresp/bresp was non-zero, or timeout
- araddr  out  ADDR_W
- arvalid  out  1
- arready  in  1
- rdata  in  DATA_W
- rresp  in  2
- rvalid  in  1
- rready  out  1
- awaddr  out  ADDR_W
- awvalid  out  1
- awready  in  1
- wdata  out  DATA_W
- wstrb  out  STRB_W
- wvalid  out  1
- wready  in  1
- bresp  in  2
- bvalid  in  1
- bready  out  1
- timeout  out  1  sticky watchdog flag (tied 0 without the feature)

Behaviour:
- Clocking and reset: one clock, clk. Reset is synchronous and active-high on rst.
  - On reset, every valid/ready output is 0 except req_ready = 1.
  - On reset, resp_rdata = 0, resp_err = 0, timeout = 0, and all address/data/strobe outputs are 0.
  - Reset mid-transaction abandons the transaction; the slaves are reset on the same rst.
- State machine states: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, RESP.
- IDLE:
  - req_ready = 1.
  - On req_valid && req_ready, latch the request. The bus address is {req_addr[ADDR_W-1:2], 2'b00}; wstrb = {0, req_wmask}.
  - Go to RD_ADDR if req_wen = 0, otherwise WR_REQ.
  - req_ready is 0 in every other state.
- RD_ADDR:
  - arvalid = 1, araddr is stable.
  - arvalid is held until arready is sampled high; it must not drop while waiting.
  - On arvalid && arready, go to RD_DATA. An arready that is already high completes the handshake in the first RD_ADDR cycle.
- RD_DATA:
  - rready = 1 for the whole state, because slaves may pulse rvalid for a single cycle.
  - On rvalid, capture rdata into resp_rdata, set resp_err = (rresp != 0), and go to RESP.
- WR_REQ:
  - awvalid and wvalid both rise on entry.
  - Each is dropped independently after its own handshake (aw_done / w_done flags). Either order is legal, and both in the same cycle is legal.
  - When both are done, go to WR_RESP.
- WR_RESP:
  - bready = 1.
  - On bvalid, set resp_err = (bresp != 0), set resp_rdata = 0, and go to RESP.
- RESP:
  - resp_valid = 1; it is held with resp_rdata/resp_err stable until resp_ready.
  - Then go to IDLE.
- Back-to-back: a new request can be accepted in the cycle after the resp handshake, not in the same cycle.
- Minimum latency with zero-wait slaves, counted as req accept to resp_valid:
  - read: 3 cycles (RD_ADDR, RD_DATA, RESP).
  - write: 3 cycles.
- A response-channel valid arriving in any state other than its own is ignored. This is a protocol violation and is flagged by an assertion.
- Bus outputs change only on clk edges (registered).

Optional Feature:
- Macro: AXIM_TIMEOUT_EN.
- When defined:
  - A counter clears on entry to RD_ADDR/WR_REQ and increments each cycle in RD_ADDR, RD_DATA, WR_REQ and WR_RESP.
  - On reaching TIMEOUT_CYCLES-1, all bus valid/ready outputs drop, the FSM goes to RESP with resp_err = 1 and resp_rdata = 0, and timeout is set.
  - timeout stays set until rst.
- When undefined: no counter, timeout = 0, and the bridge waits forever.

Decomposition:
- Shared package axil_pkg:
  - state enum (IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, RESP).
  - resp codes RESP_OKAY = 2'b00, RESP_SLVERR = 2'b10, RESP_DECERR = 2'b11.
  - default widths.
- Optional sub-module axil_watchdog (counter plus sticky flag), instantiated only under AXIM_TIMEOUT_EN.

Test Plan:
- Read, zero-wait slave: request read 0x8000_0004; slave returns 0xDEAD_BEEF with rresp = 0 → araddr = 0x8000_0004, resp_valid 3 cycles after accept, resp_rdata = 0xDEAD_BEEF, resp_err = 0.
- Write, AW ready 2 cycles before W: request write addr 0x8000_0010, data 0x1234_5678, mask 4'b0011 → wstrb = 8'h03, awvalid drops after its handshake while wvalid is held, exactly one B accepted, resp_err = 0.
- Error response: slave returns rresp = 2'b10 → resp_err = 1 with the read data still captured; the next read with OKAY gives resp_err = 0.
- Back-pressure: resp_ready held low 5 cycles → resp_valid and resp_rdata stable, req_ready = 0 throughout; a new request is accepted in the cycle after the handshake.
- Misaligned address 0x8000_0007 → araddr = 0x8000_0004.
- Timeout (AXIM_TIMEOUT_EN, TIMEOUT_CYCLES = 16): slave never asserts arready → resp_err = 1 and timeout = 1 on resp_valid; the flag persists until rst; a reset mid-read returns all outputs to their reset values on the next edge.
